// File: rtl/multicycle_ctrl_pkg.sv
// rv_ctrl_pkg: shared constants for the multi-cycle RV32I control path.
// Holds the opcode constants, the FSM state encoding and the datapath mux
// select encodings, so the controller and the datapath decode the same values.
package rv_ctrl_pkg;

   // Major opcodes (ir[6:0]) the core executes
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   // pc_sel
   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_RST    = 2'd2;

   // alu_a_sel
   localparam logic [1:0] A_PC    = 2'd0;
   localparam logic [1:0] A_OLDPC = 2'd1;
   localparam logic [1:0] A_REG   = 2'd2;
   localparam logic [1:0] A_ZERO  = 2'd3;

   // alu_b_sel
   localparam logic [1:0] B_REG  = 2'd0;
   localparam logic [1:0] B_IMM  = 2'd1;
   localparam logic [1:0] B_FOUR = 2'd2;
   localparam logic [1:0] B_UIMM = 2'd3;

   // alu_op
   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   // wb_sel
   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   // Opcodes outside the supported set, and the two unused branch funct3
   // codes, send the core to TRAP.
   function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (opc)
         OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE,
         OPC_JAL, OPC_LUI, OPC_AUIPC: ok = 1'b1;
         OPC_BRANCH:                  ok = (f3 != 3'b010) && (f3 != 3'b011);
         default:                     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle.
// master = controller (takes IR, memory ready and ALU flags; drives enables,
// selects, retire/instret/trap); slave = datapath/memory side.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      ir;
   logic             mem_ready;
   logic             alu_zero;
   logic             alu_lt;
   logic             alu_ltu;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             oldpc_ir_we;
   logic             ab_we;
   logic             aluout_we;
   logic [1:0]       alu_a_sel;
   logic [1:0]       alu_b_sel;
   logic [1:0]       alu_op;
   logic             mem_addr_sel;
   logic             mem_rd;
   logic             mem_wr;
   logic             reg_we;
   logic [1:0]       wb_sel;
   logic             retire;
   logic [CNT_W-1:0] instret;
   logic             trap;

   modport master (
      input  ir, mem_ready, alu_zero, alu_lt, alu_ltu,
      output pc_we, pc_sel, oldpc_ir_we, ab_we, aluout_we,
             alu_a_sel, alu_b_sel, alu_op, mem_addr_sel, mem_rd, mem_wr,
             reg_we, wb_sel, retire, instret, trap
   );

   modport slave (
      output ir, mem_ready, alu_zero, alu_lt, alu_ltu,
      input  pc_we, pc_sel, oldpc_ir_we, ab_we, aluout_we,
             alu_a_sel, alu_b_sel, alu_op, mem_addr_sel, mem_rd, mem_wr,
             reg_we, wb_sel, retire, instret, trap
   );
endinterface

// File: rtl/multicycle_ctrl_branch_cond.sv
// branch_cond: RV32I branch resolution from funct3 and ALU compare flags.
// Ports: funct3, zero/lt/ltu flags in; taken out. Purely combinational.
// Unused funct3 codes resolve not-taken (decode traps them anyway).
module branch_cond (
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   output logic       taken
);
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = zero;    // BEQ
         3'b001:  taken = !zero;   // BNE
         3'b100:  taken = lt;      // BLT
         3'b101:  taken = !lt;     // BGE
         3'b110:  taken = ltu;     // BLTU
         3'b111:  taken = !ltu;    // BGEU
         default: taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM of the multi-cycle RV32I core (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Ports: clk, rst_n (sync, active-low) plus the bus interface (master side).
// Latency with zero-wait memory: branch/JAL 3, ALU/LUI/AUIPC/store 4, load 5 cycles;
// each not-ready memory cycle stalls one cycle with the request held stable.
module multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter bit RESET_PC_LOAD = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multicycle_ctrl_if.master     bus
);

   state_t           state_q, state_d;
   logic             init_q;
   logic [CNT_W-1:0] instret_q;
   logic             retire;
   logic             taken;
   logic [6:0]       opc;
   logic [2:0]       f3;
   logic             is_load;
   logic             unused_ir;

   assign opc       = bus.ir[6:0];
   assign f3        = bus.ir[14:12];
   assign is_load   = (opc == OPC_LOAD);
   assign unused_ir = ^{bus.ir[31:15], bus.ir[11:7]};

   branch_cond u_branch_cond (
      .funct3 (f3),
      .zero   (bus.alu_zero),
      .lt     (bus.alu_lt),
      .ltu    (bus.alu_ltu),
      .taken  (taken)
   );

   // init_q marks the first cycle after reset release: the PC is loaded with
   // the reset vector and FETCH waits one cycle so it never reads a stale PC.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
         init_q    <= RESET_PC_LOAD;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b0;
         if (retire)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d          = state_q;
      retire           = 1'b0;
      bus.pc_we        = 1'b0;
      bus.pc_sel       = PC_ALU;
      bus.oldpc_ir_we  = 1'b0;
      bus.ab_we        = 1'b0;
      bus.aluout_we    = 1'b0;
      bus.alu_a_sel    = A_PC;
      bus.alu_b_sel    = B_REG;
      bus.alu_op       = ALU_ADD;
      bus.mem_addr_sel = 1'b0;
      bus.mem_rd       = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.reg_we       = 1'b0;
      bus.wb_sel       = WB_ALUOUT;
      bus.trap         = 1'b0;

      if (!rst_n) begin
         // everything stays at its default 0, dropping any open memory request
         state_d = S_FETCH;
      end else if (init_q) begin
         bus.pc_we  = 1'b1;
         bus.pc_sel = PC_RST;
      end else begin
         case (state_q)
            S_FETCH: begin
               bus.mem_rd    = 1'b1;
               bus.alu_a_sel = A_PC;
               bus.alu_b_sel = B_FOUR;
               if (bus.mem_ready) begin
                  bus.oldpc_ir_we = 1'b1;
                  bus.pc_we       = 1'b1;
                  state_d         = S_DECODE;
               end
            end
            S_DECODE: begin
               // ALUOUT <= OLDPC + imm: branch/JAL target ready for EXEC
               bus.ab_we     = 1'b1;
               bus.aluout_we = 1'b1;
               bus.alu_a_sel = A_OLDPC;
               bus.alu_b_sel = B_IMM;
               state_d       = is_legal(opc, f3) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
               case (opc)
                  OPC_R: begin
                     bus.alu_a_sel = A_REG;
                     bus.alu_b_sel = B_REG;
                     bus.alu_op    = ALU_FUNCT;
                     bus.aluout_we = 1'b1;
                     state_d       = S_WB;
                  end
                  OPC_IMM: begin
                     bus.alu_a_sel = A_REG;
                     bus.alu_b_sel = B_IMM;
                     bus.alu_op    = ALU_FUNCT;
                     bus.aluout_we = 1'b1;
                     state_d       = S_WB;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     bus.alu_a_sel = A_REG;
                     bus.alu_b_sel = B_IMM;
                     bus.aluout_we = 1'b1;
                     state_d       = S_MEM;
                  end
                  OPC_BRANCH: begin
                     // ALU only produces flags here; target sits in ALUOUT
                     bus.alu_a_sel = A_REG;
                     bus.alu_b_sel = B_REG;
                     bus.alu_op    = ALU_SUB;
                     if (taken) begin
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = PC_ALUOUT;
                     end
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
                  OPC_JAL: begin
                     // PC still holds OLDPC+4, which is the link value
                     bus.pc_we  = 1'b1;
                     bus.pc_sel = PC_ALUOUT;
                     bus.reg_we = 1'b1;
                     bus.wb_sel = WB_PC;
                     retire     = 1'b1;
                     state_d    = S_FETCH;
                  end
                  OPC_LUI: begin
                     bus.alu_a_sel = A_ZERO;
                     bus.alu_b_sel = B_UIMM;
                     bus.aluout_we = 1'b1;
                     state_d       = S_WB;
                  end
                  OPC_AUIPC: begin
                     bus.alu_a_sel = A_OLDPC;
                     bus.alu_b_sel = B_UIMM;
                     bus.aluout_we = 1'b1;
                     state_d       = S_WB;
                  end
                  default: state_d = S_TRAP;
               endcase
            end
            S_MEM: begin
               bus.mem_addr_sel = 1'b1;
               bus.mem_rd       = is_load;
               bus.mem_wr       = !is_load;
               if (bus.mem_ready) begin
                  if (is_load) begin
                     state_d = S_WB;
                  end else begin
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
               end
            end
            S_WB: begin
               bus.reg_we = 1'b1;
               bus.wb_sel = is_load ? WB_MDR : WB_ALUOUT;
               retire     = 1'b1;
               state_d    = S_FETCH;
            end
            S_TRAP: begin
               bus.trap = 1'b1;
            end
            default: state_d = S_TRAP;
         endcase
      end
   end

   assign bus.retire  = retire;
   assign bus.instret = rst_n ? instret_q : '0;

endmodule
